e1_calc_ctrl: RTL and testbench
===============================

// Module: e1_calc_ctrl
// PURPOSE
//  Initiator/consumer side of the e1 calculator handshake (start / s1_vld -> busy / e1 / e1_vld / e1_error).
//  Accepts one (mv, mo, s1) block from upstream, launches the calculator, times the s1_vld strobe, collects e1.
//  Range-checks and classifies e1, then forwards it downstream on a valid/ready port. Sits between count accumulator and key-rate stage.
// PARAMETERS
//  S1_DLY      6        cycles from o_start pulse to o_s1_vld pulse (calculator add-path latency); >=1
//  TIMEOUT_CYC 1024     max cycles in WAIT_E1 before timeout; >=2
//  E1_ONE      1<<24    fixed-point 1.0 of e1 (2^e1_coef_amp); upper bound of legal e1
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-high
//  i_blk_vld   in   1   upstream block valid
//  o_blk_rdy   out  1   upstream ready; high only in IDLE
//  i_mv        in   21  Mv count;  i_mo in 21 M0 count;  i_s1 in 32 S1 count
//  o_start     out  1   1-cycle launch pulse to calculator
//  o_mv/o_mo   out  21  latched counts, stable from o_start until result accepted
//  o_s1        out  32  latched S1, same stability rule
//  o_s1_vld    out  1   1-cycle pulse, exactly S1_DLY cycles after o_start
//  i_e1_busy   in   1   calculator busy
//  i_e1        in   32  calculator result;  i_e1_vld in 1 result strobe;  i_e1_error in 1 error flag
//  o_res       out  32  forwarded e1
//  o_res_code  out  2   0 OK, 1 CALC_ERR, 2 TIMEOUT, 3 RANGE
//  o_res_vld   out  1   downstream valid;  i_res_rdy in 1 downstream ready
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. rst at any state, including mid-calc, aborts to IDLE on the next edge.
//  FSM: IDLE -(i_blk_vld)-> latch inputs -> START -> WAIT_S1 -> WAIT_E1 -> HOLD -(i_res_rdy)-> IDLE.
//  START: pulse o_start only when i_e1_busy==0; otherwise stay in START (no pulse).
//  WAIT_S1: counter runs 1..S1_DLY from the cycle after o_start; o_s1_vld on the cycle the count hits S1_DLY; -> WAIT_E1.
//  WAIT_E1: sample i_e1/i_e1_error on the first i_e1_vld and go to HOLD.
//   i_e1_error=1 -> code 1, o_res=i_e1.  i_e1>E1_ONE -> code 3, o_res=E1_ONE (saturate).  Else code 0.
//   Priority: CALC_ERR > RANGE.
//   Timeout counter reaches TIMEOUT_CYC with no i_e1_vld -> code 2, o_res=0, -> HOLD.
//   i_e1_vld on the same cycle as the timeout: the result wins (not a timeout).
//  HOLD: o_res_vld=1; o_res/o_res_code held stable until i_res_rdy; o_res_vld drops the cycle after the handshake.
//  i_e1_vld outside WAIT_E1 (stale or late): ignored, no state change.
//  i_s1==0: forwarded unchanged; the calculator returns 0.
//  o_blk_rdy=1 only in IDLE. A new block is accepted no earlier than the cycle after the downstream handshake.
//  Arithmetic: compare only, unsigned 32-bit; no math on e1.
// CONFIGURATION
//  E1_CTRL_STAT_EN defined: adds ports o_blk_cnt[15:0] (blocks completed) and o_err_cnt[15:0] (codes 1-3).
//   Both counters saturate at 0xFFFF, clear on rst, and increment on the downstream handshake.
//  Not defined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package e1_pkg: FSM state enum (IDLE, START, WAIT_S1, WAIT_E1, HOLD); result code constants
//   (E1_OK, E1_CALC_ERR, E1_TIMEOUT, E1_RANGE); default E1_ONE.
//  Sub-module e1_ctrl_timer: one loadable up-counter with terminal-count flag.
//   Shared by WAIT_S1 (terminal count S1_DLY) and WAIT_E1 (terminal count TIMEOUT_CYC); cleared on state entry.
// TESTING
//  1 Block mv=1000, mo=10, s1=5000; stub returns e1=0x0004_0000 -> o_start is one pulse; o_s1_vld exactly 6 cycles later;
//    o_res=0x0004_0000, code 0.
//  2 Stub never asserts i_e1_vld -> TIMEOUT_CYC cycles after entering WAIT_E1: o_res_vld=1, o_res=0, code 2.
//  3 Stub returns e1=0x0200_0000, error=0 -> o_res=0x0100_0000, code 3. With error=1 -> o_res=0x0200_0000, code 1.
//  4 i_res_rdy low for 10 cycles in HOLD -> o_res/o_res_code stable; o_blk_rdy=0; a second i_blk_vld is not accepted.
//  5 rst asserted in WAIT_E1 -> all outputs 0 on the next cycle. i_e1_vld two cycles later -> no o_res_vld.
//  6 i_e1_busy held high 5 cycles at START -> o_start delayed until busy falls.
//    With E1_CTRL_STAT_EN: after tests 1-3, o_blk_cnt=4, o_err_cnt=3.

Source files
------------

// File: rtl/e1_pkg.sv
// Shared types and constants for the e1 calculator controller: FSM states,
// result codes, the default fixed-point 1.0 of e1, and the result classifier.
package e1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_S1,
        WAIT_E1,
        HOLD
    } state_t;

    typedef logic [1:0] res_code_t;

    localparam res_code_t E1_OK       = 2'd0;
    localparam res_code_t E1_CALC_ERR = 2'd1;
    localparam res_code_t E1_TIMEOUT  = 2'd2;
    localparam res_code_t E1_RANGE    = 2'd3;

    localparam logic [31:0] E1_ONE_DEFAULT = 32'h0100_0000;

    // A calculator error outranks an out-of-range value.
    function automatic res_code_t classify(input logic [31:0] e1, input logic err,
                                           input logic [31:0] one);
        return err ? E1_CALC_ERR : ((e1 > one) ? E1_RANGE : E1_OK);
    endfunction

endpackage

// File: rtl/e1_ctrl_timer.sv
// Loadable up-counter with terminal-count flag; load restarts the count at 1,
// and the count holds once it reaches the terminal value.
module e1_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(1);
        end else if (en && !tc) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/e1_calc_ctrl.sv
// Initiator/consumer controller for the e1 calculator handshake.
// Optional block/error statistics counters are enabled by defining E1_CTRL_STAT_EN.
module e1_calc_ctrl
    import e1_pkg::*;
#(
    parameter int unsigned S1_DLY      = 6,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] E1_ONE      = E1_ONE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_blk_vld,
    output logic        o_blk_rdy,
    input  logic [20:0] i_mv,
    input  logic [20:0] i_mo,
    input  logic [31:0] i_s1,
    output logic        o_start,
    output logic [20:0] o_mv,
    output logic [20:0] o_mo,
    output logic [31:0] o_s1,
    output logic        o_s1_vld,
    input  logic        i_e1_busy,
    input  logic [31:0] i_e1,
    input  logic        i_e1_vld,
    input  logic        i_e1_error,
    output logic [31:0] o_res,
    output logic [1:0]  o_res_code,
    output logic        o_res_vld,
    input  logic        i_res_rdy
`ifdef E1_CTRL_STAT_EN
    ,
    output logic [15:0] o_blk_cnt,
    output logic [15:0] o_err_cnt
`endif
);

    localparam int unsigned T_MAX = (S1_DLY > TIMEOUT_CYC) ? S1_DLY : TIMEOUT_CYC;
    localparam int          TW    = $clog2(T_MAX + 1);

    state_t          state, state_next;
    logic [TW-1:0]   t_term;
    logic            t_load, t_en, t_tc;
    logic            accept, launch, res_take, handshake;

    // One timer serves both waits; its terminal count follows the current state.
    assign t_term = (state == WAIT_S1) ? TW'(S1_DLY) : TW'(TIMEOUT_CYC);

    e1_ctrl_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (t_load),
        .en   (t_en),
        .term (t_term),
        .tc   (t_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        t_load     = 1'b0;
        t_en       = 1'b0;
        accept     = 1'b0;
        launch     = 1'b0;
        res_take   = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (i_blk_vld) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (!i_e1_busy) begin
                    launch     = 1'b1;
                    t_load     = 1'b1;
                    state_next = WAIT_S1;
                end
            end
            WAIT_S1: begin
                t_en = 1'b1;
                if (t_tc) begin
                    t_load     = 1'b1;
                    state_next = WAIT_E1;
                end
            end
            WAIT_E1: begin
                t_en = 1'b1;
                // A strobe on the timeout cycle still counts as a result.
                if (i_e1_vld || t_tc) begin
                    res_take   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (i_res_rdy) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_start   = launch;
    assign o_s1_vld  = (state == WAIT_S1) && t_tc;
    assign o_res_vld = (state == HOLD);
    assign o_blk_rdy = (state == IDLE) && !rst;

    // NOTE: the data registers are reset too, because every output must read
    // zero after reset, not just the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            o_mv       <= '0;
            o_mo       <= '0;
            o_s1       <= '0;
            o_res      <= '0;
            o_res_code <= E1_OK;
        end else begin
            state <= state_next;
            if (accept) begin
                o_mv <= i_mv;
                o_mo <= i_mo;
                o_s1 <= i_s1;
            end
            if (res_take) begin
                if (i_e1_vld) begin
                    o_res_code <= classify(i_e1, i_e1_error, E1_ONE);
                    o_res      <= (!i_e1_error && (i_e1 > E1_ONE)) ? E1_ONE : i_e1;
                end else begin
                    o_res_code <= E1_TIMEOUT;
                    o_res      <= '0;
                end
            end
        end
    end

`ifdef E1_CTRL_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_blk_cnt <= '0;
            o_err_cnt <= '0;
        end else if (handshake) begin
            if (o_blk_cnt != 16'hFFFF) o_blk_cnt <= o_blk_cnt + 16'd1;
            if (o_res_code != E1_OK && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_e1_calc_ctrl.sv
// Self-checking bench for e1_calc_ctrl: directed and randomized blocks against a
// behavioural model of the result classification and handshake timing.
module tb_e1_calc_ctrl;

    localparam int          S1_DLY = 6;
    localparam int          TO     = 1024;
    localparam logic [31:0] ONE    = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_blk_vld, o_blk_rdy;
    logic [20:0] i_mv, i_mo, o_mv, o_mo;
    logic [31:0] i_s1, o_s1;
    logic        o_start, o_s1_vld;
    logic        i_e1_busy, i_e1_vld, i_e1_error;
    logic [31:0] i_e1, o_res;
    logic [1:0]  o_res_code;
    logic        o_res_vld, i_res_rdy;
`ifdef E1_CTRL_STAT_EN
    logic [15:0] o_blk_cnt, o_err_cnt;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int blk_m  = 0;
    int err_m  = 0;

    always #5 clk = ~clk;

    e1_calc_ctrl #(.S1_DLY(S1_DLY), .TIMEOUT_CYC(TO), .E1_ONE(ONE)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_blk_vld  (i_blk_vld),
        .o_blk_rdy  (o_blk_rdy),
        .i_mv       (i_mv),
        .i_mo       (i_mo),
        .i_s1       (i_s1),
        .o_start    (o_start),
        .o_mv       (o_mv),
        .o_mo       (o_mo),
        .o_s1       (o_s1),
        .o_s1_vld   (o_s1_vld),
        .i_e1_busy  (i_e1_busy),
        .i_e1       (i_e1),
        .i_e1_vld   (i_e1_vld),
        .i_e1_error (i_e1_error),
        .o_res      (o_res),
        .o_res_code (o_res_code),
        .o_res_vld  (o_res_vld),
        .i_res_rdy  (i_res_rdy)
`ifdef E1_CTRL_STAT_EN
        ,
        .o_blk_cnt  (o_blk_cnt),
        .o_err_cnt  (o_err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_blk_vld  = 1'b0;
        i_e1_busy  = 1'b0;
        i_e1_vld   = 1'b0;
        i_e1_error = 1'b0;
        i_e1       = '0;
        i_res_rdy  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 128'({o_start, o_s1_vld, o_res_vld, o_blk_rdy, o_res_code, o_res,
                         o_mv, o_mo, o_s1}), 128'(0));
    endtask

    // One complete block: calculator stub behaviour and downstream readiness are
    // set by the arguments; the model predicts code, value and every event cycle.
    task automatic run_block(input string name, input logic [20:0] mv, input logic [20:0] mo,
                             input logic [31:0] s1, input int busy_cyc, input bit respond,
                             input int e1_lat, input logic [31:0] e1, input bit err,
                             input int rdy_wait, input bit stale);
        logic [1:0]  exp_code;
        logic [31:0] exp_res;
        logic [1:0]  code_first;
        logic [31:0] res_first;
        bit          got;
        bit          stable  = 1'b1;
        bit          done    = 1'b0;
        int          start_k = -1;
        int          s1_k    = -1;
        int          res_k   = -1;
        int          n_start = 0;
        int          n_s1    = 0;
        int          exp_res_k;

        got = respond && (e1_lat <= TO);
        if (!got) begin
            exp_code = 2'd2; exp_res = 32'd0;
        end else if (err) begin
            exp_code = 2'd1; exp_res = e1;
        end else if (e1 > ONE) begin
            exp_code = 2'd3; exp_res = ONE;
        end else begin
            exp_code = 2'd0; exp_res = e1;
        end
        code_first = '0;
        res_first  = '0;

        i_blk_vld = 1'b1;
        i_mv = mv; i_mo = mo; i_s1 = s1;
        i_e1_busy = (busy_cyc > 0);
        @(negedge clk);
        check({name, " blk_rdy_idle"}, 128'(o_blk_rdy), 128'(1));
        tick();

        for (int k = 1; k <= TO + 200 && !done; k++) begin
            i_mv       = 21'($urandom);
            i_mo       = 21'($urandom);
            i_s1       = $urandom;
            i_e1_busy  = (k <= busy_cyc);
            i_e1_vld   = 1'b0;
            i_e1       = $urandom;
            i_e1_error = 1'($urandom);
            if (stale && start_k > 0 && k == start_k + 2) i_e1_vld = 1'b1;
            if (respond && s1_k > 0 && k == s1_k + e1_lat) begin
                i_e1_vld = 1'b1; i_e1 = e1; i_e1_error = err;
            end
            i_res_rdy = (res_k > 0) && (k >= res_k + rdy_wait);
            i_blk_vld = (res_k > 0);
            @(negedge clk);
            if (o_start) begin n_start++; start_k = k; end
            if (o_s1_vld) begin n_s1++; s1_k = k; end
            if (o_res_vld) begin
                if (res_k < 0) begin
                    res_k = k; res_first = o_res; code_first = o_res_code;
                end
                if (o_res !== exp_res || o_res_code !== exp_code || o_blk_rdy !== 1'b0 ||
                    o_mv !== mv || o_mo !== mo || o_s1 !== s1) stable = 1'b0;
                if (i_res_rdy) done = 1'b1;
            end
            tick();
        end

        exp_res_k = got ? (s1_k + e1_lat + 1) : (s1_k + TO + 1);
        check({name, " handshake_seen"}, 128'(done), 128'(1));
        check({name, " start_pulses"}, 128'(n_start), 128'(1));
        check({name, " start_cycle"}, 128'(start_k), 128'(busy_cyc + 1));
        check({name, " s1_vld_pulses"}, 128'(n_s1), 128'(1));
        check({name, " s1_vld_delay"}, 128'(s1_k - start_k), 128'(S1_DLY));
        check({name, " res_vld_cycle"}, 128'(res_k), 128'(exp_res_k));
        check({name, " res_value"}, 128'(res_first), 128'(exp_res));
        check({name, " res_code"}, 128'(code_first), 128'(exp_code));
        check({name, " hold_stable"}, 128'(stable), 128'(1));

        idle_inputs();
        @(negedge clk);
        check({name, " res_vld_drop"}, 128'(o_res_vld), 128'(0));
        check({name, " blk_rdy_back"}, 128'(o_blk_rdy), 128'(1));
        if (done) begin
            blk_m++;
            if (exp_code != 2'd0) err_m++;
        end
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [31:0] e1;
        int          sel;

        rst = 1'b1;
        idle_inputs();
        i_mv = '0; i_mo = '0; i_s1 = '0;
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        run_block("t1_ok", 21'd1000, 21'd10, 32'd5000, 0, 1'b1, 3, 32'h0004_0000, 1'b0, 0, 1'b0);
        run_block("t2_timeout", 21'd7, 21'd8, 32'd9, 0, 1'b0, 0, 32'd0, 1'b0, 0, 1'b0);
        run_block("t3_range", 21'd1, 21'd2, 32'd3, 0, 1'b1, 2, 32'h0200_0000, 1'b0, 0, 1'b0);
        run_block("t3_calc_err", 21'd4, 21'd5, 32'd6, 0, 1'b1, 2, 32'h0200_0000, 1'b1, 0, 1'b0);
`ifdef E1_CTRL_STAT_EN
        check("stat_blk_cnt", 128'(o_blk_cnt), 128'(blk_m));
        check("stat_err_cnt", 128'(o_err_cnt), 128'(err_m));
`endif
        run_block("t4_hold10", 21'h1FFFFF, 21'h0AAAAA, 32'hDEAD_BEEF, 0, 1'b1, 5, 32'h0000_1234, 1'b0, 10, 1'b0);
        run_block("t6_busy5", 21'd11, 21'd22, 32'd33, 5, 1'b1, 1, 32'h0080_0000, 1'b0, 1, 1'b0);
        run_block("e1_eq_one", 21'd3, 21'd3, 32'd3, 0, 1'b1, 4, ONE, 1'b0, 0, 1'b0);
        run_block("e1_one_p1", 21'd3, 21'd3, 32'd3, 0, 1'b1, 4, ONE + 32'd1, 1'b0, 0, 1'b0);
        run_block("s1_zero", 21'd0, 21'd0, 32'd0, 0, 1'b1, 1, 32'd0, 1'b0, 0, 1'b0);
        run_block("stale_vld", 21'd5, 21'd6, 32'd7, 2, 1'b1, 6, 32'h0000_0042, 1'b0, 2, 1'b1);
        run_block("vld_at_timeout", 21'd9, 21'd9, 32'd9, 0, 1'b1, TO, 32'h0000_0777, 1'b0, 0, 1'b0);
        run_block("vld_late", 21'd9, 21'd9, 32'd9, 0, 1'b1, TO + 1, 32'h0000_0777, 1'b0, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       e1 = $urandom_range(0, ONE);
                1:       e1 = ONE + $urandom_range(1, 1000);
                2:       e1 = $urandom;
                default: e1 = ONE;
            endcase
            run_block("rand", 21'($urandom), 21'($urandom), $urandom,
                      int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                      int'($urandom_range(1, 20)), e1, ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 4)), 1'($urandom));
        end
`ifdef E1_CTRL_STAT_EN
        check("stat_blk_cnt_end", 128'(o_blk_cnt), 128'(blk_m));
        check("stat_err_cnt_end", 128'(o_err_cnt), 128'(err_m));
`endif

        // Reset in the middle of WAIT_E1, then a stale result strobe.
        i_blk_vld = 1'b1; i_mv = 21'd100; i_mo = 21'd200; i_s1 = 32'd300;
        tick();
        i_blk_vld = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (o_s1_vld) seen = 1'b1;
            tick();
        end
        check("rst_reach_wait_e1", 128'(seen), 128'(1));
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero("rst_mid_calc_outputs");
`ifdef E1_CTRL_STAT_EN
        check("rst_stat_cleared", 128'({o_blk_cnt, o_err_cnt}), 128'(0));
`endif
        rst = 1'b0;
        tick();
        tick();
        i_e1_vld = 1'b1; i_e1 = 32'h0000_1234;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_res_vld || o_start || o_s1_vld) seen = 1'b1;
            tick();
            i_e1_vld = 1'b0;
        end
        check("rst_late_vld_ignored", 128'(seen), 128'(0));
        @(negedge clk);
        check("rst_blk_rdy_idle", 128'(o_blk_rdy), 128'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
